// File: rtl/sw_in_pkg.sv
// Shared constants, read-address map and debounce state type for the
// switch input port.
package sw_in_pkg;

  localparam int SW_W    = 10;
  localparam int FIELD_W = 5;

  localparam logic [1:0] ADDR_PORT0  = 2'd0;
  localparam logic [1:0] ADDR_PORT1  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_EVCNT  = 2'd3;

  typedef enum logic {
    DB_IDLE   = 1'b0,
    DB_SETTLE = 1'b1
  } db_state_e;

  // Operand fields are presented to the CPU as zero-extended 32-bit words.
  function automatic logic [31:0] field_word(input logic [FIELD_W-1:0] f);
    return {{(32-FIELD_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus IDLE/SETTLE debounce FSM for the switch vector.
// o_commit_new is high in the cycle whose closing edge commits a new value.
module sw_debounce
  import sw_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_stable,
  output logic            o_commit_new
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_cand;
  logic [SW_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt;
  db_state_e        r_state;

  logic [SW_W-1:0]  w_cand_nxt;
  logic [SW_W-1:0]  w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  db_state_e        w_state_nxt;
  logic             w_commit_new;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_commit_new = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (r_sync2 != r_stable) begin
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = '0;
          w_state_nxt = DB_SETTLE;
        end
      end
      DB_SETTLE: begin
        // Any movement of the input restarts the settle window on the new level.
        if (r_sync2 != r_cand) begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stable_nxt = r_cand;
          w_commit_new = (r_cand != r_stable);
          w_state_nxt  = DB_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = DB_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_state  <= DB_IDLE;
    end else begin
      r_sync1  <= i_sw;
      r_sync2  <= r_sync1;
      r_cand   <= w_cand_nxt;
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  end

  assign o_stable     = r_stable;
  assign o_commit_new = w_commit_new;

endmodule

// File: rtl/sw_in_port.sv
// Debounced memory-mapped switch input port: operand ports, sticky changed
// flag and registered read port. SW_IN_PORT_EVCNT_EN adds the commit counter.
module sw_in_port
  import sw_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EVCNT_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] sw,
  input  logic            rd_en,
  input  logic [1:0]      rd_addr,
  output logic [31:0]     rd_data,
  output logic [31:0]     in_port0,
  output logic [31:0]     in_port1,
  output logic            changed
);

  logic [SW_W-1:0]    w_stable;
  logic               w_commit_new;
  logic               w_status_rd;
  logic [EVCNT_W-1:0] w_evcnt;
  logic [31:0]        w_rd_word;
  logic               r_changed;
  logic [31:0]        r_rd_data;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .i_sw        (sw),
    .o_stable    (w_stable),
    .o_commit_new(w_commit_new)
  );

  assign in_port0 = field_word(w_stable[SW_W-1 -: FIELD_W]);
  assign in_port1 = field_word(w_stable[FIELD_W-1:0]);

  assign w_status_rd = rd_en && (rd_addr == ADDR_STATUS);

  // A commit on the same edge as a status read wins: the flag stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_changed <= 1'b0;
    end else if (w_commit_new) begin
      r_changed <= 1'b1;
    end else if (w_status_rd) begin
      r_changed <= 1'b0;
    end
  end

`ifdef SW_IN_PORT_EVCNT_EN
  logic [EVCNT_W-1:0] r_evcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evcnt <= '0;
    end else if (w_commit_new) begin
      r_evcnt <= r_evcnt + EVCNT_W'(1);
    end
  end

  assign w_evcnt = r_evcnt;
`else
  assign w_evcnt = '0;
`endif

  always_comb begin
    w_rd_word = '0;
    case (rd_addr)
      ADDR_PORT0:  w_rd_word = in_port0;
      ADDR_PORT1:  w_rd_word = in_port1;
      ADDR_STATUS: w_rd_word = {31'b0, r_changed};
      ADDR_EVCNT:  w_rd_word = 32'(w_evcnt);
      default:     w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= w_rd_word;
    end
  end

  assign rd_data = r_rd_data;
  assign changed = r_changed;

endmodule

// File: tb/tb_sw_in_port.sv
// Self-checking bench for sw_in_port: sliding-window reference model compared
// every cycle, plus hand-computed directed expectations.
module tb_sw_in_port;

  localparam int N       = 8;
  localparam int EVCNT_W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  sw = 10'h3FF;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        changed;

  int total = 0;
  int bad   = 0;

  sw_in_port #(
    .DEBOUNCE_CYCLES(N),
    .EVCNT_W        (EVCNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .in_port0(in_port0),
    .in_port1(in_port1),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a value is accepted once the synchronized input has
  // shown the same level on N+1 consecutive clock edges and differs from
  // the currently accepted value.
  int m_d1, m_d2, m_stable, m_evcnt, m_rd;
  bit m_changed;
  int m_win[$];

  function automatic int evcnt_read(input int cnt);
`ifdef SW_IN_PORT_EVCNT_EN
    return cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_stable = 0; m_evcnt = 0; m_rd = 0; m_changed = 0;
    m_win = {};
    for (int i = 0; i < N + 1; i++) m_win.push_back(0);
  endtask

  task automatic model_step();
    int  y;
    bit  same;
    y = m_d2;
    m_win.push_back(y);
    void'(m_win.pop_front());
    same = 1'b1;
    foreach (m_win[i]) if (m_win[i] != y) same = 1'b0;
    if (rd_en) begin
      case (int'(rd_addr))
        0: m_rd = m_stable / 32;
        1: m_rd = m_stable % 32;
        2: m_rd = m_changed ? 1 : 0;
        default: m_rd = evcnt_read(m_evcnt);
      endcase
      if (rd_addr == 2'd2) m_changed = 1'b0;
    end
    if (same && y != m_stable) begin
      m_stable  = y;
      m_changed = 1'b1;
      m_evcnt   = (m_evcnt + 1) % (1 << EVCNT_W);
    end
    m_d2 = m_d1;
    m_d1 = int'(sw);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc in_port0", in_port0, 32'(m_stable / 32));
      check("cyc in_port1", in_port1, 32'(m_stable % 32));
      check("cyc changed", 32'(changed), 32'(m_changed));
      check("cyc rd_data", rd_data, 32'(m_rd));
    end
  end

  task automatic hold_sw(input logic [9:0] v, input int n);
    sw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_en = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    #1 reset = 1'b0;
    repeat (n) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all switches high; outputs must be zero while in reset.
    repeat (3) @(negedge clk);
    check("rst in_port0", in_port0, 32'd0);
    check("rst in_port1", in_port1, 32'd0);
    check("rst changed", 32'(changed), 32'd0);
    check("rst rd_data", rd_data, 32'd0);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    check("edge10 changed", 32'(changed), 32'd0);
    check("edge10 in_port0", in_port0, 32'd0);
    @(negedge clk);
    check("edge11 changed", 32'(changed), 32'd1);
    check("edge11 in_port0", in_port0, 32'd31);
    check("edge11 in_port1", in_port1, 32'd31);
    do_read(2'd2);
    check("status read", rd_data, 32'd1);
    check("status cleared", 32'(changed), 32'd0);

    // Reset mid-settle discards the candidate; the level is re-debounced.
    hold_sw(10'h155, 5);
    do_reset(2);
    repeat (10) @(negedge clk);
    check("rerun edge10 changed", 32'(changed), 32'd0);
    @(negedge clk);
    check("rerun edge11 changed", 32'(changed), 32'd1);
    check("rerun in_port0", in_port0, 32'd10);
    check("rerun in_port1", in_port1, 32'd21);

    // Bounce between two levels, then settle on 10'h021.
    sw = 10'h000;
    do_reset(2);
    for (int i = 0; i < 10; i++) hold_sw((i % 2 == 0) ? 10'h021 : 10'h000, 3);
    hold_sw(10'h021, 15);
    check("bounce in_port0", in_port0, 32'd1);
    check("bounce in_port1", in_port1, 32'd1);
    check("bounce changed", 32'(changed), 32'd1);
    do_read(2'd3);
`ifdef SW_IN_PORT_EVCNT_EN
    check("bounce evcnt", rd_data, 32'd1);
`else
    check("bounce evcnt", rd_data, 32'd0);
`endif

    // Return to zero, clear the flag, then a short glitch must not commit.
    hold_sw(10'h000, 15);
    do_read(2'd2);
    check("clear before glitch", 32'(changed), 32'd0);
    hold_sw(10'h001, 5);
    hold_sw(10'h000, 15);
    check("glitch changed", 32'(changed), 32'd0);
    check("glitch in_port1", in_port1, 32'd0);

    // Status read on the commit edge: old value returned, flag stays set.
    hold_sw(10'h3E0, 10);
    rd_en = 1'b1;
    rd_addr = 2'd2;
    @(negedge clk);
    check("coincident read data", rd_data, 32'd0);
    check("coincident changed", 32'(changed), 32'd1);
    check("coincident in_port0", in_port0, 32'd31);
    @(negedge clk);
    rd_en = 1'b0;
    check("second read data", rd_data, 32'd1);
    check("second read changed", 32'(changed), 32'd0);

    // Five distinct commits wrap a 2-bit counter to 1.
    sw = 10'h000;
    do_reset(2);
    for (int v = 1; v <= 5; v++) hold_sw(10'(v), 12);
    do_read(2'd3);
`ifdef SW_IN_PORT_EVCNT_EN
    check("wrap evcnt", rd_data, 32'd1);
`else
    check("wrap evcnt", rd_data, 32'd0);
`endif
    do_read(2'd0);
    check("wrap port0 read", rd_data, 32'd0);
    do_read(2'd1);
    check("wrap port1 read", rd_data, 32'd5);
    do_read(2'd1);
    check("back-to-back port1", rd_data, 32'd5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
